// File: rtl/timed_event_scheduler.sv
// In-order timestamped event queue. Each head event is presented downstream once
// system time reaches its timestamp, using a half-range window so wrap-around works.
module timed_event_scheduler_slot #(
  parameter int D_W = 20,
  parameter int T_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we_i,
  input  logic [D_W-1:0] data_i,
  input  logic [T_W-1:0] time_i,
  output logic [D_W-1:0] data_o,
  output logic [T_W-1:0] time_o
);
  logic [D_W-1:0] data_q;
  logic [T_W-1:0] time_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      time_q <= '0;
    end else if (we_i) begin
      data_q <= data_i;
      time_q <= time_i;
    end
  end

  assign data_o = data_q;
  assign time_o = time_q;
endmodule

module timed_event_scheduler #(
  parameter int D_W   = 20,
  parameter int T_W   = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     unit_pulse,
  input  logic                     enable,
  input  logic                     time_clear,
  input  logic [D_W-1:0]           in_data,
  input  logic [T_W-1:0]           in_time,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [D_W-1:0]           out_data,
  output logic                     out_late,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [T_W-1:0]           cur_time,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               late_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [T_W-1:0] HALF = {1'b1, {(T_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [T_W-1:0]      time_q, time_d;
  logic [D_W-1:0]      odata_q, odata_d;
  logic                olate_q, olate_d;
  logic [7:0]          lcnt_q, lcnt_d;

  logic [DEPTH-1:0][D_W-1:0] slot_data;
  logic [DEPTH-1:0][T_W-1:0] slot_time;
  logic [DEPTH-1:0]          slot_we;

  logic [D_W-1:0] head_data;
  logic [T_W-1:0] head_time, head_age;
  logic           push, load, due, ovalid;

  // Storage slots; only the tail slot is written on a push.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_we[i] = push && (wr_ptr_q == AW'(i));
    timed_event_scheduler_slot #(.D_W(D_W), .T_W(T_W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .we_i  (slot_we[i]),
      .data_i(in_data),
      .time_i(in_time),
      .data_o(slot_data[i]),
      .time_o(slot_time[i])
    );
  end

  assign head_data = slot_data[rd_ptr_q];
  assign head_time = slot_time[rd_ptr_q];
  assign head_age  = time_q - head_time;

  assign ovalid   = (state_q == ST_HOLD);
  assign in_ready = (fill_q < FW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Head is due when it lies in the past half of the time circle (or now).
  assign due      = (fill_q != '0) && enable && (head_age < HALF);
  assign load     = due && (!ovalid || out_ready);

  always_comb begin
    time_d = time_q;
    if (time_clear)
      time_d = '0;
    else if (enable && unit_pulse)
      time_d = time_q + T_W'(1);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (load) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !load)
      fill_d = fill_q + FW'(1);
    else if (!push && load)
      fill_d = fill_q - FW'(1);
  end

  always_comb begin
    odata_d = odata_q;
    olate_d = olate_q;
    lcnt_d  = lcnt_q;
    if (load) begin
      odata_d = head_data;
      olate_d = (head_time != time_q);
      if ((head_time != time_q) && (lcnt_q != 8'hFF))
        lcnt_d = lcnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_WAIT;
      ST_WAIT:  if (load) state_d = ST_HOLD;
      ST_HOLD: begin
        if (load)
          state_d = ST_HOLD;
        else if (out_ready)
          state_d = (fill_d != '0) ? ST_WAIT : ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      time_q   <= '0;
      odata_q  <= '0;
      olate_q  <= 1'b0;
      lcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      time_q   <= time_d;
      odata_q  <= odata_d;
      olate_q  <= olate_d;
      lcnt_q   <= lcnt_d;
    end
  end

  assign out_valid  = ovalid;
  assign out_data   = odata_q;
  assign out_late   = olate_q;
  assign cur_time   = time_q;
  assign fill       = fill_q;
  assign late_count = lcnt_q;
endmodule

// File: doc/timed_event_scheduler.md
Name: timed_event_scheduler

Overview:
- Holds timestamped events in an in-order queue and releases each one downstream once the system time reaches its timestamp.
- System time is a counter advanced by the single-cycle unit pulse from the time-unit pulser (1–64K clocks per unit).
- Sits between the host/decoder input stream and the downstream datapath, so tagged words are delivered at programmed times.
- No reordering: events are released strictly in arrival order (head-of-line).

Parameters:
- D_W, 20, payload width in bits.
- T_W, 16, timestamp and system-time width in bits; arithmetic is modulo 2^T_W.
- DEPTH, 8, queue depth; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- unit_pulse  in  1  one-cycle time-unit tick from the pulser.
- enable  in  1  when 0, time is frozen and no release occurs; queue input still accepted.
- time_clear  in  1  synchronous clear of system time to 0.
- in_data  in  D_W  event payload.
- in_time  in  T_W  event release time.
- in_valid  in  1  input handshake valid.
- in_ready  out  1  input handshake ready.
- out_data  out  D_W  released payload.
- out_late  out  1  released event's time was strictly before cur_time at load.
- out_valid  out  1  output handshake valid.
- out_ready  in  1  output handshake ready.
- cur_time  out  T_W  current system time.
- fill  out  $clog2(DEPTH)+1  number of events in the queue, excluding the output register.
- late_count  out  8  saturating count of late releases.

Behaviour:
- Reset: cur_time=0, fill=0, out_valid=0, out_data=0, out_late=0, late_count=0, in_ready=1; queue pointers cleared. All state is cleared immediately on reset assertion, mid-transfer included; no event survives.
- Time counter, per clock edge:
  - time_clear=1 → cur_time=0. This has priority over unit_pulse in the same cycle.
  - Else enable=1 and unit_pulse=1 → cur_time+1, wrapping from 2^T_W−1 to 0.
  - Else cur_time holds.
- Input handshake:
  - in_ready = (fill < DEPTH). It is registered-state only, with no combinational path from out_ready.
  - A transfer occurs when in_valid=1 and in_ready=1; in_data and in_time are written to the queue tail.
- Due test on the queue head: due = fill>0 and enable=1 and ((cur_time − head_time) mod 2^T_W) < 2^(T_W−1). This gives a half-range window, so wrap-around is handled. A head more than half the range in the past is treated as future.
- Output register load:
  - Load happens at an edge when due=1 and (out_valid=0 or out_ready=1).
  - On load: out_data ← head payload; out_late ← (head_time != cur_time); the head is popped.
  - If out_late=1 on load, late_count increments, saturating at 255.
  - If out_valid=1 and out_ready=1 with no load, out_valid falls to 0.
  - out_data and out_late hold stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - An event accepted at edge k that is already due appears with out_valid=1 after edge k+1.
  - Throughput is one event per cycle with out_ready held high and all heads due.
- Push and pop in the same cycle leave fill unchanged. This is legal at any fill from 1 to DEPTH−1; at fill=DEPTH in_ready=0, so only the pop occurs.
- Controller states, encoded from fill and out_valid:
  - EMPTY: fill=0, out_valid=0.
  - WAIT: fill>0, head not due, out_valid=0.
  - HOLD: out_valid=1.
  - Transitions: EMPTY→WAIT on push; WAIT→HOLD on due; HOLD→HOLD on ready with the next head due; HOLD→WAIT or EMPTY on ready otherwise.
- Deasserting enable freezes time and blocks loads. An event already in the output register stays presented until accepted.
- time_clear does not flush the queue. Queued timestamps are re-evaluated against the new time.

Test Plan:
- Reset, then push {data=0x00A5, time=3} with enable=1, pulser at 4 clk/unit, out_ready=1 → out_valid rises the cycle after cur_time becomes 3; out_late=0; late_count=0.
- Push 8 events with time=100 while cur_time=0 → in_ready=0 after the 8th push, fill=8; a 9th in_valid is not accepted. At cur_time=100 with out_ready=1, 8 back-to-back outputs are released in order, then fill=0 and in_ready=1.
- Set cur_time=10, push time=5 → released one cycle after acceptance with out_late=1 and late_count=1; 300 such events → late_count saturates at 255.
- Wrap: cur_time=0xFFFE, push time=0x0001 → not released until cur_time=0x0001 after wrapping, out_late=0. Push time=0x8000 at cur_time=0x0000 → not due.
- Backpressure: out_ready=0 with 3 due events → out_valid=1 and out_data stable for 20 cycles with fill=2; then out_ready=1 → 3 outputs on consecutive cycles.
- time_clear and unit_pulse in the same cycle → cur_time=0. Assert reset while in HOLD with fill=4 → out_valid=0 and fill=0 immediately, cur_time=0.
